// File: rtl/mips_16_prog_loader_pkg.sv
// Shared constants for the mips_16 program loader: the frame start marker and
// the 3-bit loader FSM state encodings.
package mips_16_prog_loader_pkg;

    localparam logic [7:0] LOADER_START_BYTE = 8'hA5;

    localparam logic [2:0] LDR_IDLE    = 3'd0;
    localparam logic [2:0] LDR_COUNT   = 3'd1;
    localparam logic [2:0] LDR_DATA_HI = 3'd2;
    localparam logic [2:0] LDR_DATA_LO = 3'd3;
    localparam logic [2:0] LDR_CHECK   = 3'd4;
    localparam logic [2:0] LDR_FINISH  = 3'd5;
    localparam logic [2:0] LDR_ERR     = 3'd6;

endpackage

// File: rtl/mips_16_loader_word_asm.sv
// Pairs high/low bytes into an instruction word and issues the registered
// single-cycle imem write one cycle after the low byte is accepted.
module mips_16_loader_word_asm
    import mips_16_prog_loader_pkg::*;
#(
    parameter int INSTR_WIDTH = 16,
    parameter int ADDR_WIDTH  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             byte_in,
    input  logic                   hi_en,
    input  logic                   lo_en,
    input  logic [ADDR_WIDTH-1:0]  addr_in,
    output logic                   we,
    output logic [ADDR_WIDTH-1:0]  addr,
    output logic [INSTR_WIDTH-1:0] wdata
);

    logic [7:0]             hi_q, hi_d;
    logic                   we_q, we_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [INSTR_WIDTH-1:0] wdata_q, wdata_d;

    always_comb begin
        hi_d    = hi_en ? byte_in : hi_q;
        we_d    = lo_en;
        addr_d  = lo_en ? addr_in : addr_q;
        wdata_d = lo_en ? {hi_q, byte_in} : wdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q    <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            hi_q    <= hi_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // A write already registered is dropped if rst arrives in its cycle.
    assign we    = we_q & ~rst;
    assign addr  = addr_q;
    assign wdata = wdata_q;

endmodule

// File: rtl/mips_16_prog_loader.sv
// Hardware program loader: framed byte stream -> sequential imem writes, core
// held in reset during the load. Checksum byte enabled by MIPS_16_LOADER_CHECKSUM_EN.
module mips_16_prog_loader
    import mips_16_prog_loader_pkg::*;
#(
    parameter int         INSTR_WIDTH = 16,
    parameter int         ADDR_WIDTH  = 8,
    parameter logic [7:0] START_BYTE  = LOADER_START_BYTE
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   imem_we,
    output logic [ADDR_WIDTH-1:0]  imem_addr,
    output logic [INSTR_WIDTH-1:0] imem_wdata,
    output logic                   core_rst,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    // One extra bit so a COUNT of 0 can hold the full 2^ADDR_WIDTH words.
    localparam int CNT_WIDTH = ADDR_WIDTH + 1;

    logic [2:0]            state_q, state_d;
    logic [CNT_WIDTH-1:0]  rem_q, rem_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  core_rst_q, core_rst_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  rdy_q, rdy_d;
    logic                  hi_en, lo_en, xfer, is_start;
`ifdef MIPS_16_LOADER_CHECKSUM_EN
    logic [7:0]            chk_q, chk_d;
    logic                  err_q, err_d;
`endif

    assign in_ready = rdy_q & ~rst;
    assign xfer     = in_valid & in_ready;
    assign is_start = (in_data == START_BYTE);

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        addr_d     = addr_q;
        core_rst_d = core_rst_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        rdy_d      = 1'b1;
        hi_en      = 1'b0;
        lo_en      = 1'b0;
`ifdef MIPS_16_LOADER_CHECKSUM_EN
        chk_d      = chk_q;
        err_d      = err_q;
`endif
        // Release the core the cycle after the done pulse, unless a new frame already began.
        if (done_q && state_q == LDR_IDLE) begin
            core_rst_d = 1'b0;
            busy_d     = 1'b0;
        end
        case (state_q)
            LDR_IDLE, LDR_FINISH, LDR_ERR: begin
                if (state_q == LDR_FINISH) begin
                    done_d  = 1'b1;
                    state_d = LDR_IDLE;
                end
                if (xfer && is_start) begin
                    state_d    = LDR_COUNT;
                    core_rst_d = 1'b1;
                    busy_d     = 1'b1;
`ifdef MIPS_16_LOADER_CHECKSUM_EN
                    err_d      = 1'b0;
`endif
                end
            end
            LDR_COUNT: begin
                if (xfer) begin
                    rem_d   = (in_data == 8'd0) ? CNT_WIDTH'(1 << ADDR_WIDTH)
                                                : CNT_WIDTH'(in_data);
                    addr_d  = '0;
                    state_d = LDR_DATA_HI;
`ifdef MIPS_16_LOADER_CHECKSUM_EN
                    chk_d   = in_data;
`endif
                end
            end
            LDR_DATA_HI: begin
                if (xfer) begin
                    hi_en   = 1'b1;
                    state_d = LDR_DATA_LO;
`ifdef MIPS_16_LOADER_CHECKSUM_EN
                    chk_d   = chk_q ^ in_data;
`endif
                end
            end
            LDR_DATA_LO: begin
                if (xfer) begin
                    lo_en  = 1'b1;
                    addr_d = addr_q + 1'b1;
                    rem_d  = rem_q - 1'b1;
`ifdef MIPS_16_LOADER_CHECKSUM_EN
                    chk_d  = chk_q ^ in_data;
                    state_d = (rem_q == CNT_WIDTH'(1)) ? LDR_CHECK : LDR_DATA_HI;
`else
                    state_d = (rem_q == CNT_WIDTH'(1)) ? LDR_FINISH : LDR_DATA_HI;
`endif
                end
            end
`ifdef MIPS_16_LOADER_CHECKSUM_EN
            LDR_CHECK: begin
                if (xfer) begin
                    if (in_data == chk_q) begin
                        state_d = LDR_FINISH;
                    end else begin
                        state_d = LDR_ERR;
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                    end
                end
            end
`endif
            default: state_d = LDR_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= LDR_IDLE;
            rem_q      <= '0;
            addr_q     <= '0;
            core_rst_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rdy_q      <= 1'b0;
`ifdef MIPS_16_LOADER_CHECKSUM_EN
            chk_q      <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            addr_q     <= addr_d;
            core_rst_q <= core_rst_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rdy_q      <= rdy_d;
`ifdef MIPS_16_LOADER_CHECKSUM_EN
            chk_q      <= chk_d;
            err_q      <= err_d;
`endif
        end
    end

    mips_16_loader_word_asm #(
        .INSTR_WIDTH (INSTR_WIDTH),
        .ADDR_WIDTH  (ADDR_WIDTH)
    ) u_word_asm (
        .clk     (clk),
        .rst     (rst),
        .byte_in (in_data),
        .hi_en   (hi_en),
        .lo_en   (lo_en),
        .addr_in (addr_q),
        .we      (imem_we),
        .addr    (imem_addr),
        .wdata   (imem_wdata)
    );

    assign core_rst = core_rst_q;
    assign busy     = busy_q;
    assign done     = done_q;
`ifdef MIPS_16_LOADER_CHECKSUM_EN
    assign err      = err_q;
`else
    assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_mips_16_prog_loader.sv
// Bench for mips_16_prog_loader: table of frames checked against a stream-parsing
// reference model, plus hand sequences for latency, reset and mid-frame rst.
module tb_mips_16_prog_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [15:0] imem_wdata;
    logic        core_rst, busy, done, err;

    always #5 clk = ~clk;

    mips_16_prog_loader dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_rst   (core_rst),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    typedef struct packed {
        logic [7:0]  a;
        logic [15:0] d;
    } wr_t;

    typedef struct {
        int nw;
        int pat;       // 0: 1234/5678/9ABC, 1: random, 2: A5A5, 3: word index
        bit junk;
        bit bad;
        bit exp_err;
        bit exp_crst;
    } vec_t;

    int checks = 0;
    int passed = 0;

    wr_t         wlog[$];
    wr_t         exp_wr[$];
    bit          exp_ok;
    logic [15:0] mem[256];
    logic [7:0]  frame[$];
    logic [15:0] words[$];
    logic [15:0] fixed3[3] = '{16'h1234, 16'h5678, 16'h9ABC};
    vec_t        vecs[$];
    int          done_cnt;
    logic        rst_at_done, rst_after_done, prev_done;
    bit          gaps_en;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Write/done observer, sampled on the falling edge.
    always @(negedge clk) begin
        if (imem_we) begin
            wlog.push_back({imem_addr, imem_wdata});
            mem[imem_addr] = imem_wdata;
        end
        if (prev_done) rst_after_done = core_rst;
        if (done) begin
            done_cnt++;
            rst_at_done = core_rst;
        end
        prev_done = done;
    end

    task automatic clear_obs();
        wlog.delete();
        done_cnt       = 0;
        rst_at_done    = 1'b0;
        rst_after_done = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        if (gaps_en) repeat ($urandom_range(0, 1)) @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic build_frame(input bit bad);
        int n;
        logic [7:0] c;
        n = words.size();
        c = n[7:0];
        frame.delete();
        frame.push_back(8'hA5);
        frame.push_back(c);
        foreach (words[k]) begin
            frame.push_back(words[k][15:8]);
            frame.push_back(words[k][7:0]);
            c = c ^ words[k][15:8] ^ words[k][7:0];
        end
`ifdef MIPS_16_LOADER_CHECKSUM_EN
        frame.push_back(bad ? ~c : c);
`else
        if (bad) frame.push_back(~c);
`endif
    endtask

    // Reference: parse the byte stream as a frame and list the writes it implies.
    task automatic model_frame();
        int i = 0;
        int n;
        logic [7:0] x;
        exp_wr.delete();
        exp_ok = 1'b0;
        while (i < frame.size() && frame[i] != 8'hA5) i++;
        if (i + 1 >= frame.size()) return;
        n = (frame[i+1] == 8'd0) ? 256 : int'(frame[i+1]);
        x = frame[i+1];
        for (int k = 0; k < n; k++) begin
            exp_wr.push_back({k[7:0], frame[i+2+2*k], frame[i+3+2*k]});
            x = x ^ frame[i+2+2*k] ^ frame[i+3+2*k];
        end
`ifdef MIPS_16_LOADER_CHECKSUM_EN
        exp_ok = (frame[i+2+2*n] == x);
`else
        exp_ok = 1'b1;
`endif
    endtask

    task automatic run_vec(input vec_t v);
        int bad_cnt = 0;
        words.delete();
        for (int k = 0; k < v.nw; k++) begin
            case (v.pat)
                0:       words.push_back(fixed3[k % 3]);
                1:       words.push_back(16'($urandom));
                2:       words.push_back(16'hA5A5);
                default: words.push_back(k[15:0]);
            endcase
        end
        gaps_en = (v.pat == 1);
        @(negedge clk);
        if (v.junk) begin
            clear_obs();
            send_byte(8'h00);
            send_byte(8'hFF);
            send_byte(8'h3C);
            repeat (3) @(negedge clk);
            check("junk_writes", wlog.size(), 0);
            check("junk_busy", 32'(busy), 0);
            check("junk_core_rst", 32'(core_rst), 0);
        end
        clear_obs();
        build_frame(v.bad);
        model_frame();
        foreach (frame[i]) send_byte(frame[i]);
        repeat (6) @(negedge clk);
        check("write_count", wlog.size(), exp_wr.size());
        for (int k = 0; k < exp_wr.size() && k < wlog.size(); k++)
            if (wlog[k] !== exp_wr[k]) bad_cnt++;
        check("write_contents", bad_cnt, 0);
        check("done_count", done_cnt, exp_ok ? 1 : 0);
        check("err", 32'(err), 32'(v.exp_err));
        check("core_rst", 32'(core_rst), 32'(v.exp_crst));
        check("busy_idle", 32'(busy), 0);
        if (exp_ok) begin
            check("core_rst_at_done", 32'(rst_at_done), 1);
            check("core_rst_after_done", 32'(rst_after_done), 0);
        end
        if (v.pat == 0 && exp_ok) check("fetch_pc0", 32'(mem[0]), 32'h1234);
        gaps_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = 8'h00;
        gaps_en = 1'b0;
        prev_done = 1'b0;
        clear_obs();

        vecs.push_back('{nw: 3,   pat: 0, junk: 0, bad: 0, exp_err: 0, exp_crst: 0});
        vecs.push_back('{nw: 3,   pat: 0, junk: 1, bad: 0, exp_err: 0, exp_crst: 0});
        vecs.push_back('{nw: 7,   pat: 1, junk: 0, bad: 0, exp_err: 0, exp_crst: 0});
        vecs.push_back('{nw: 2,   pat: 2, junk: 0, bad: 0, exp_err: 0, exp_crst: 0});
`ifdef MIPS_16_LOADER_CHECKSUM_EN
        vecs.push_back('{nw: 3,   pat: 0, junk: 0, bad: 1, exp_err: 1, exp_crst: 1});
        vecs.push_back('{nw: 3,   pat: 0, junk: 0, bad: 0, exp_err: 0, exp_crst: 0});
`endif
        vecs.push_back('{nw: 256, pat: 3, junk: 0, bad: 0, exp_err: 0, exp_crst: 0});
        vecs.push_back('{nw: 1,   pat: 1, junk: 0, bad: 0, exp_err: 0, exp_crst: 0});

        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_imem_we", 32'(imem_we), 0);
        check("rst_imem_addr", 32'(imem_addr), 0);
        check("rst_imem_wdata", 32'(imem_wdata), 0);
        check("rst_core_rst", 32'(core_rst), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_rst", 32'(in_ready), 1);

        // Start-byte effect and single-cycle write latency
        clear_obs();
        send_byte(8'hA5);
        check("start_core_rst", 32'(core_rst), 1);
        check("start_busy", 32'(busy), 1);
        send_byte(8'h01);
        send_byte(8'h12);
        send_byte(8'h34);
        check("lat_we", 32'(imem_we), 1);
        check("lat_addr", 32'(imem_addr), 0);
        check("lat_wdata", 32'(imem_wdata), 32'h1234);
        @(negedge clk);
        check("lat_we_one_cycle", 32'(imem_we), 0);
`ifdef MIPS_16_LOADER_CHECKSUM_EN
        send_byte(8'h27);
`endif
        repeat (4) @(negedge clk);
        check("lat_done", done_cnt, 1);
        check("lat_released", 32'(core_rst), 0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // rst after DATA_HI of word 1
        clear_obs();
        @(negedge clk);
        send_byte(8'hA5);
        send_byte(8'h03);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", 32'(in_ready), 0);
        check("midrst_core_rst", 32'(core_rst), 0);
        check("midrst_busy", 32'(busy), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_writes", wlog.size(), 1);
        check("midrst_done", done_cnt, 0);
        run_vec(vecs[0]);

        // rst in the same cycle as a pending write
        clear_obs();
        @(negedge clk);
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h77);
        in_data  = 8'h88;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check("suppressed_we", 32'(imem_we), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("suppressed_writes", wlog.size(), 0);
        run_vec(vecs[2]);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
